circular_buffer_fifo: RTL

Parametrised circular buffer with independent write and read handshakes. It generalises the fixed four-cell, eight-bit buffer in width and depth, adds full/empty/occupancy tracking, and has a selectable overwrite-oldest mode. It sits between a producer that streams words and a consumer that drains them at its own rate. One storage word is read out per accepted read, with registered output.

---
 rtl/circular_buffer_fifo.sv | 99 +++++++++
 1 files changed

// File: rtl/circular_buffer_fifo.sv
// Parametrised circular buffer with independent write/read handshakes,
// registered read data, occupancy flags and optional overwrite-oldest mode.
module circular_buffer_fifo #(
    parameter int WORD_SIZE = 8,
    parameter int BUFF_SIZE = 4,
    parameter int PTR_WIDTH = 2,
    parameter int OVERWRITE = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(BUFF_SIZE);
    localparam logic [PTR_WIDTH:0] CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [WORD_SIZE-1:0] mem [BUFF_SIZE];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;

    logic                 rd_ok;
    logic                 wr_ok;
    logic                 wr_blocked;
    logic                 wr_over;
    logic                 mem_we;
    logic [PTR_WIDTH:0]   count_nxt;

    always_comb begin
        rd_ok      = rd_en && !empty;
        wr_ok      = wr_en && (!full || rd_ok);
        wr_blocked = wr_en && full && !rd_ok;
        wr_over    = wr_blocked && (OVERWRITE != 0);
        mem_we     = wr_ok || wr_over;
        count_nxt  = count;
        if (wr_ok && !rd_ok)
            count_nxt = count + CNT_ONE;
        else if (rd_ok && !wr_ok)
            count_nxt = count - CNT_ONE;
    end

    // Cell contents survive a clear; only the async reset wipes them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUFF_SIZE; i++)
                mem[i] <= '0;
        end else if (!clear && mem_we) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (mem_we)
                wr_ptr <= wr_ptr + PTR_ONE;
            // An overwrite discards the oldest word by stepping the read side too.
            if (rd_ok || wr_over)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (rd_ok)
                data_out <= mem[rd_ptr];
            count      <= count_nxt;
            full       <= (count_nxt == FULL_CNT);
            empty      <= (count_nxt == '0);
            data_valid <= rd_ok;
            overflow   <= wr_blocked;
            underflow  <= rd_en && empty;
        end
    end

endmodule
